// File: rtl/bcd_serial_sequencer.sv
// Digit-serial multi-digit BCD add/subtract sequencer.
// Time-shares one single-digit BCD adder, one digit per clock, LSD first.
// Optional subtract support is built only when BCD_SEQ_SUB_EN is defined;
// otherwise i_op is ignored and every operation is an addition.
module bcd_serial_sequencer #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned CNT_W  = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_op,
   input  logic [4*DIGITS-1:0]   i_a,
   input  logic [4*DIGITS-1:0]   i_b,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_result,
   output logic                  o_cout,
   output logic                  o_err
);

   localparam int unsigned W = 4 * DIGITS;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [W-1:0]       r_result;
   logic               r_cout;
   logic               r_err;

   logic               w_accept;
   logic               w_bad;
   logic               w_sub;
   logic [W-1:0]       w_b_cap;
   logic [4:0]         w_sum;
   logic               w_carry_nxt;
   logic [3:0]         w_digit;
   logic               w_last;

   assign w_accept = i_start && (r_state != S_RUN);
   assign w_last   = (r_cnt == LAST_CNT);

`ifdef BCD_SEQ_SUB_EN
   assign w_sub = i_op;

   // B operand as captured: 9's complement of each digit when subtracting
   always_comb begin
      w_b_cap = i_b;
      if (i_op) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            w_b_cap[4*i +: 4] = 4'd9 - i_b[4*i +: 4];
         end
      end
   end
`else
   logic w_unused_op;

   assign w_sub       = 1'b0;
   assign w_unused_op = i_op;

   // B operand captured unchanged: addition only
   always_comb begin
      w_b_cap = i_b;
   end
`endif

   // Flag any operand nibble outside 0..9
   always_comb begin
      w_bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if ((i_a[4*i +: 4] > 4'd9) || (i_b[4*i +: 4] > 4'd9)) begin
            w_bad = 1'b1;
         end
      end
   end

   // Single-digit BCD adder with decimal correction
   always_comb begin
      w_sum       = 5'(r_a[3:0]) + 5'(r_b[3:0]) + 5'(r_carry);
      w_carry_nxt = (w_sum > 5'd9);
      w_digit     = w_carry_nxt ? 4'(w_sum + 5'd6) : w_sum[3:0];
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; an accepted start in IDLE or DONE launches a new op
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_state_nxt = w_bad ? S_DONE : S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand shifters, digit counter, carry chain and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == S_RUN);
         r_done <= (w_state_nxt == S_DONE);
         if (w_accept) begin
            r_a     <= i_a;
            r_b     <= w_b_cap;
            r_carry <= w_sub;
            r_cnt   <= '0;
            r_err   <= w_bad;
            if (w_bad) begin
               r_result <= '0;
               r_cout   <= 1'b0;
            end
         end else if (r_state == S_RUN) begin
            r_a      <= {4'd0, r_a[W-1:4]};
            r_b      <= {4'd0, r_b[W-1:4]};
            r_carry  <= w_carry_nxt;
            r_result <= {w_digit, r_result[W-1:4]};
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
               r_cout <= w_carry_nxt;
            end
         end
      end
   end

   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_result = r_result;
   assign o_cout   = r_cout;
   assign o_err    = r_err;

endmodule

// File: tb/tb_bcd_serial_sequencer.sv
// Scoreboard bench for bcd_serial_sequencer: 4-digit and 8-digit instances
// checked against a decimal reference model. Follows BCD_SEQ_SUB_EN.
module tb_bcd_serial_sequencer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic        s4_start, s4_op;
   logic [15:0] s4_a, s4_b;
   logic        w4_busy, w4_done, w4_cout, w4_err;
   logic [15:0] w4_res;

   logic        s8_start, s8_op;
   logic [31:0] s8_a, s8_b;
   logic        w8_busy, w8_done, w8_cout, w8_err;
   logic [31:0] w8_res;

   bcd_serial_sequencer #(.DIGITS(4), .CNT_W(3)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_start(s4_start), .i_op(s4_op),
      .i_a(s4_a), .i_b(s4_b), .o_busy(w4_busy), .o_done(w4_done),
      .o_result(w4_res), .o_cout(w4_cout), .o_err(w4_err)
   );

   bcd_serial_sequencer #(.DIGITS(8), .CNT_W(3)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_start(s8_start), .i_op(s8_op),
      .i_a(s8_a), .i_b(s8_b), .o_busy(w8_busy), .o_done(w8_done),
      .o_result(w8_res), .o_cout(w8_cout), .o_err(w8_err)
   );

   typedef struct packed {
      logic [31:0] res;
      logic        cout;
      logic        err;
   } exp_t;

   exp_t q4[$];
   exp_t q8[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Single comparison point for the whole bench
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Decimal reference: operands converted to integers, arithmetic done in base 10
   function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic op, input int digits);
      exp_t   e;
      longint va, vb, m, r;
      logic   bad, sub;
      logic [3:0] da, db;
      e = '0; va = 0; vb = 0; m = 1; bad = 1'b0;
      for (int i = digits - 1; i >= 0; i--) begin
         da = a[4*i +: 4];
         db = b[4*i +: 4];
         if (da > 4'd9 || db > 4'd9) bad = 1'b1;
         va = va * 10 + longint'(da);
         vb = vb * 10 + longint'(db);
         m  = m * 10;
      end
      if (bad) begin
         e.err = 1'b1;
         return e;
      end
`ifdef BCD_SEQ_SUB_EN
      sub = op;
`else
      sub = op & 1'b0;
`endif
      if (sub) begin
         r      = va - vb;
         e.cout = (r >= 0);
         if (r < 0) r = r + m;
      end else begin
         r      = va + vb;
         e.cout = (r >= m);
         if (r >= m) r = r - m;
      end
      for (int i = 0; i < digits; i++) begin
         e.res[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return e;
   endfunction

   function automatic logic [31:0] gen_bcd(input int digits);
      logic [31:0] v;
      int          mode, k;
      v    = '0;
      mode = int'($urandom_range(0, 9));
      for (int i = 0; i < digits; i++) begin
         v[4*i +: 4] = (mode == 0) ? 4'd9 : (mode == 1) ? 4'd0 : 4'($urandom_range(0, 9));
      end
      if (mode == 2) begin
         k = int'($urandom_range(0, digits - 1));
         v[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      return v;
   endfunction

   // Scoreboard monitors: pop an expectation on every done pulse
   always @(negedge clk) begin
      exp_t e;
      if (!rst && w4_done) begin
         if (q4.size() == 0) begin
            check_eq("d4_unexpected_done", 64'(w4_done), 64'd0);
         end else begin
            e = q4.pop_front();
            check_eq("d4_result", 64'(w4_res), 64'(e.res[15:0]));
            check_eq("d4_cout", 64'(w4_cout), 64'(e.cout));
            check_eq("d4_err", 64'(w4_err), 64'(e.err));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && w8_done) begin
         if (q8.size() == 0) begin
            check_eq("d8_unexpected_done", 64'(w8_done), 64'd0);
         end else begin
            e = q8.pop_front();
            check_eq("d8_result", 64'(w8_res), 64'(e.res));
            check_eq("d8_cout", 64'(w8_cout), 64'(e.cout));
            check_eq("d8_err", 64'(w8_err), 64'(e.err));
         end
      end
   end

   // Issue one op on the 4-digit DUT from the current negedge; returns at done
   task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic op);
      exp_t e;
      int   n, nb;
      e  = ref_model(32'(a), 32'(b), op, 4);
      n  = 0;
      nb = 0;
      s4_a = a; s4_b = b; s4_op = op; s4_start = 1'b1;
      if (!w4_busy) q4.push_back(e);
      do begin
         @(negedge clk);
         if (n == 0) begin
            s4_start = 1'b0;
            s4_a     = 16'($urandom);
            s4_b     = 16'($urandom);
            s4_op    = 1'($urandom);
         end
         n++;
         if (w4_busy) nb++;
      end while (!w4_done && n < 40);
      check_eq("d4_latency", 64'(n), e.err ? 64'd1 : 64'd5);
      check_eq("d4_busy_cycles", 64'(nb), e.err ? 64'd0 : 64'd4);
   endtask

   task automatic run8(input logic [31:0] a, input logic [31:0] b, input logic op);
      exp_t e;
      int   n;
      e = ref_model(a, b, op, 8);
      n = 0;
      s8_a = a; s8_b = b; s8_op = op; s8_start = 1'b1;
      if (!w8_busy) q8.push_back(e);
      do begin
         @(negedge clk);
         if (n == 0) begin
            s8_start = 1'b0;
            s8_a     = $urandom;
            s8_b     = $urandom;
         end
         n++;
      end while (!w8_done && n < 60);
      check_eq("d8_latency", 64'(n), e.err ? 64'd1 : 64'd9);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      s4_start = 1'b0; s4_op = 1'b0; s4_a = '0; s4_b = '0;
      s8_start = 1'b0; s8_op = 1'b0; s8_a = '0; s8_b = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", 64'(w4_busy), 64'd0);
      check_eq("rst_done", 64'(w4_done), 64'd0);
      check_eq("rst_result", 64'(w4_res), 64'd0);
      check_eq("rst_cout", 64'(w4_cout), 64'd0);
      check_eq("rst_err", 64'(w4_err), 64'd0);
      check_eq("rst_result8", 64'(w8_res), 64'd0);
      rst = 1'b0;

      // Plain add
      @(negedge clk);
      run4(16'h1234, 16'h5678, 1'b0);
      check_eq("add_result", 64'(w4_res), 64'h6912);
      check_eq("add_cout", 64'(w4_cout), 64'd0);
      @(negedge clk);
      check_eq("done_single_cycle", 64'(w4_done), 64'd0);
      check_eq("result_held", 64'(w4_res), 64'h6912);

      // Overflow then back-to-back start in the done cycle
      run4(16'h9999, 16'h0001, 1'b0);
      check_eq("ovf_result", 64'(w4_res), 64'h0000);
      check_eq("ovf_cout", 64'(w4_cout), 64'd1);
      run4(16'h0045, 16'h0055, 1'b0);
      check_eq("b2b_result", 64'(w4_res), 64'h0100);
      check_eq("b2b_cout", 64'(w4_cout), 64'd0);

      // Invalid digit, then a valid op clears err
      @(negedge clk);
      run4(16'h12A4, 16'h0001, 1'b0);
      check_eq("bad_err", 64'(w4_err), 64'd1);
      check_eq("bad_result", 64'(w4_res), 64'd0);
      check_eq("bad_cout", 64'(w4_cout), 64'd0);
      @(negedge clk);
      run4(16'h0001, 16'h0001, 1'b0);
      check_eq("clear_err", 64'(w4_err), 64'd0);
      check_eq("clear_result", 64'(w4_res), 64'h0002);

      // Subtract (sums when the feature is not built)
      @(negedge clk);
      run4(16'h0500, 16'h0123, 1'b1);
`ifdef BCD_SEQ_SUB_EN
      check_eq("sub_ge_result", 64'(w4_res), 64'h0377);
      check_eq("sub_ge_cout", 64'(w4_cout), 64'd1);
`else
      check_eq("sub_ge_result", 64'(w4_res), 64'h0623);
      check_eq("sub_ge_cout", 64'(w4_cout), 64'd0);
`endif
      @(negedge clk);
      run4(16'h0123, 16'h0500, 1'b1);
`ifdef BCD_SEQ_SUB_EN
      check_eq("sub_lt_result", 64'(w4_res), 64'h9623);
`else
      check_eq("sub_lt_result", 64'(w4_res), 64'h0623);
`endif
      check_eq("sub_lt_cout", 64'(w4_cout), 64'd0);

      // Start re-pulsed during RUN is ignored
      @(negedge clk);
      s4_a = 16'h1111; s4_b = 16'h2222; s4_op = 1'b0; s4_start = 1'b1;
      q4.push_back(ref_model(32'h1111, 32'h2222, 1'b0, 4));
      @(negedge clk);
      s4_start = 1'b0;
      @(negedge clk);
      check_eq("abuse_busy", 64'(w4_busy), 64'd1);
      s4_a = 16'h9999; s4_b = 16'h9999; s4_start = 1'b1;
      @(negedge clk);
      s4_start = 1'b0;
      n = 3;
      while (!w4_done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq("abuse_latency", 64'(n), 64'd5);
      check_eq("abuse_result", 64'(w4_res), 64'h3333);

      // Reset on the second RUN cycle aborts the op
      @(negedge clk);
      s4_a = 16'h4321; s4_b = 16'h1111; s4_op = 1'b0; s4_start = 1'b1;
      @(negedge clk);
      s4_start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("midrst_busy", 64'(w4_busy), 64'd0);
      check_eq("midrst_result", 64'(w4_res), 64'd0);
      check_eq("midrst_done", 64'(w4_done), 64'd0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check_eq("midrst_no_done", 64'(w4_done), 64'd0);
      end

      // Reset wins over a simultaneous start
      rst = 1'b1; s4_start = 1'b1; s4_a = 16'h0001; s4_b = 16'h0001;
      @(negedge clk);
      rst = 1'b0; s4_start = 1'b0;
      check_eq("rst_start_busy", 64'(w4_busy), 64'd0);
      @(negedge clk);
      check_eq("rst_start_idle", 64'(w4_busy), 64'd0);

      // Randomized traffic on both widths
      fork
         for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) != 0) @(negedge clk);
            run4(16'(gen_bcd(4)), 16'(gen_bcd(4)), 1'($urandom));
         end
         begin
            @(negedge clk);
            for (int i = 0; i < 500; i++) begin
               if ($urandom_range(0, 3) != 0) @(negedge clk);
               run8(gen_bcd(8), gen_bcd(8), 1'($urandom));
            end
         end
      join

      repeat (4) @(negedge clk);
      check_eq("q4_drained", 64'(q4.size()), 64'd0);
      check_eq("q8_drained", 64'(q8.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
